fir_tap_scheduler: RTL and testbench
====================================

// Module: fir_tap_scheduler
// PURPOSE
//  Sequences fir_filter_multi. Drives its coefficient-bank select and enable. Accepts bank-switch requests over a req/ack handshake.
//  Qualifies the filter output with o_valid, low during pipeline fill and during coefficient settling after a bank switch.
//  Sits beside the FIR in the Rx/Tx chain; o_valid gates downstream consumers of o_os_data.
// PARAMETERS
//  NUM_COEFF  17  filter taps; must match the FIR instance
//  PIPE_LAT    5  edges from a change on FIR i_sel_taps until o_os_data reflects the new bank (coeff reg + prod + 3 sum stages)
//  NB_SEL      2  bank-select width (4 banks)
//  NB_SWCNT    8  width of switch-event counter
//  NB_CNT is a localparam: $clog2(NUM_COEFF+PIPE_LAT).
// PORTS
//  clk           in   1         system clock
//  i_reset_n     in   1         asynchronous active-low reset
//  i_enable      in   1         run request for the filter path
//  i_sw_req      in   1         bank-switch request (level; held until o_sw_ack)
//  i_sw_bank     in   NB_SEL    requested bank, stable while i_sw_req=1
//  o_sw_ack      out  1         1-cycle pulse: request accepted
//  o_sel_taps    out  NB_SEL    to FIR i_sel_taps (registered)
//  o_fir_en      out  1         to FIR i_en (registered)
//  o_valid       out  1         FIR output qualifier (registered)
//  o_busy        out  1         1 in FILL or SWITCH
//  o_sw_count    out  NB_SWCNT  accepted bank changes, wraps modulo 2^NB_SWCNT
// BEHAVIOUR
//  Reset values: state DISABLED, o_sel_taps=0, o_fir_en=0, o_valid=0, o_sw_ack=0, o_busy=0, o_sw_count=0, cnt=0.
//  States:
//  - DISABLED: o_fir_en=0, o_valid=0. i_enable=1 -> FILL, cnt=NUM_COEFF+PIPE_LAT-1, o_fir_en=1 at the same edge.
//  - FILL: cnt decrements each edge. At cnt==1 -> RUN and o_valid=1.
//    With defaults, o_valid rises 21 edges after o_fir_en rises (full 17-sample window through the pipeline).
//  - RUN: o_valid=1.
//  - SWITCH: o_valid=0, cnt decrements. At cnt==1 -> RUN, o_valid=1. o_valid is low for exactly PIPE_LAT cycles.
//  Handshake:
//  - A request is accepted on the edge where i_sw_req=1 and state is DISABLED, FILL or RUN.
//  - On acceptance: o_sw_ack=1 for one cycle and o_sel_taps<=i_sw_bank at the same edge.
//  - Requests are not accepted in SWITCH; o_sw_ack stays low and the requester holds.
//  - The requester must drop i_sw_req the cycle after ack. A still-high req is treated as a new request.
//  Switch effects:
//  - i_sw_bank != o_sel_taps: o_sw_count++.
//  - In RUN: -> SWITCH, cnt=PIPE_LAT.
//  - In FILL: stay in FILL, cnt=max(cnt,PIPE_LAT).
//  - In DISABLED: select updated, state unchanged.
//  - i_sw_bank == o_sel_taps: ack only. No count, no state change, o_valid unaffected.
//  Priority: i_enable=0 wins over everything.
//  - Any state -> DISABLED next edge. o_fir_en=0 and o_valid=0 at that edge; the FIR clears its pipeline.
//  - A request in the same cycle is still accepted if the state allows it (select updated), but causes no SWITCH.
//  - cnt is cleared.
//  i_enable re-asserted in the cycle after deassert restarts a full FILL.
//  Asynchronous reset mid-operation returns all outputs to reset values immediately. The first i_enable after release starts FILL.
//  o_busy = (state==FILL || state==SWITCH), registered alongside the state.
//  No combinational path from inputs to outputs.
// STRUCTURE
//  Package fir_ctrl_pkg holds:
//  - state encoding localparams ST_DISABLED, ST_FILL, ST_RUN, ST_SWITCH;
//  - FIR pipeline latency constant PIPE_LAT_DEF=5;
//  - function settle_len(num_coeff, pipe_lat), shared with the FIR testbench.
//  Sub-module fir_settle_timer holds the loadable down-counter:
//  - inputs i_load, i_load_val, i_clear;
//  - output o_done pulse when the count reaches 1.
//  The FSM, handshake and counters stay in the top module.
// TESTING
//  1 Reset, then i_enable=1 at cycle 0 -> o_fir_en=1 after edge 1; o_valid=1 after edge 22; o_busy=1 in between.
//  2 RUN, req bank 2 (cur 0) -> ack pulse; o_sel_taps=2 same edge; o_valid low exactly 5 cycles; o_sw_count=1.
//  3 RUN, req bank equal to current -> ack pulse; o_valid stays 1; o_sw_count unchanged.
//  4 SWITCH, new req bank 3 held -> no ack until RUN; ack on first RUN edge; a second 5-cycle blank follows.
//  5 FILL at cnt=10, req bank 1 -> ack; fill completes on the original schedule. At cnt=3 -> fill extends to 5 more cycles.
//  6 i_enable=0 during SWITCH -> DISABLED next edge, o_valid=0, o_fir_en=0. Assert i_reset_n=0 mid-FILL -> all outputs 0 asynchronously.
//  Bench checks o_valid against a FIR reference model output and confirms correct bank taps at every valid sample.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR tap scheduler:
// state encoding, pipeline latency and fill-length helper.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_FILL     = 2'd1,
    ST_RUN      = 2'd2,
    ST_SWITCH   = 2'd3
  } state_e;

  localparam int PIPE_LAT_DEF = 5;

  // Edges from FIR enable until a full window reaches the output.
  function automatic int settle_len(
    input int num_coeff,
    input int pipe_lat
  );
    return num_coeff + pipe_lat - 1;
  endfunction

endpackage

// File: rtl/fir_settle_timer.sv
// Loadable down-counter timing FIR fill and coefficient settling.
// o_done flags the last counted edge (count == 1).
module fir_settle_timer #(
  parameter int NB_CNT = 5
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_load,
  input  logic [NB_CNT-1:0] i_load_val,
  input  logic              i_clear,
  output logic              o_done,
  output logic [NB_CNT-1:0] o_cnt
);

  localparam logic [NB_CNT-1:0] ONE = NB_CNT'(1);

  logic [NB_CNT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == ONE);
  assign o_cnt  = cnt_q;

endmodule

// File: rtl/fir_tap_scheduler.sv
// Sequences fir_filter_multi: enable, bank select, bank-switch
// handshake and an output qualifier covering fill and settling.
module fir_tap_scheduler
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_COEFF = 17,
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int NB_SEL    = 2,
  parameter int NB_SWCNT  = 8
) (
  input  logic                clk,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_sw_req,
  input  logic [NB_SEL-1:0]   i_sw_bank,
  output logic                o_sw_ack,
  output logic [NB_SEL-1:0]   o_sel_taps,
  output logic                o_fir_en,
  output logic                o_valid,
  output logic                o_busy,
  output logic [NB_SWCNT-1:0] o_sw_count
);

  localparam int NB_CNT = $clog2(NUM_COEFF + PIPE_LAT);
  localparam logic [NB_CNT-1:0] FILL_LEN =
    NB_CNT'(settle_len(NUM_COEFF, PIPE_LAT));
  localparam logic [NB_CNT-1:0] SW_LEN = NB_CNT'(PIPE_LAT);
  localparam logic [NB_CNT-1:0] ONE    = NB_CNT'(1);

  state_e              state_q, state_d;
  logic [NB_SEL-1:0]   sel_q, sel_d;
  logic [NB_SWCNT-1:0] swcnt_q, swcnt_d;
  logic                en_q, en_d;
  logic                valid_q, valid_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;

  logic                accept, change;
  logic                ld, clr, done;
  logic [NB_CNT-1:0]   ld_val, cnt;

  fir_settle_timer #(
    .NB_CNT (NB_CNT)
  ) u_timer (
    .clk        (clk),
    .i_reset_n  (i_reset_n),
    .i_load     (ld),
    .i_load_val (ld_val),
    .i_clear    (clr),
    .o_done     (done),
    .o_cnt      (cnt)
  );

  always_comb begin
    accept  = i_sw_req && (state_q != ST_SWITCH);
    change  = accept && (i_sw_bank != sel_q);
    sel_d   = accept ? i_sw_bank : sel_q;
    swcnt_d = swcnt_q + NB_SWCNT'(change);
    ack_d   = accept;
    en_d    = i_enable;
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = cnt;
    clr     = 1'b0;
    if (!i_enable) begin
      state_d = ST_DISABLED;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        ST_DISABLED: begin
          state_d = ST_FILL;
          ld      = 1'b1;
          ld_val  = FILL_LEN;
        end
        ST_FILL: begin
          // New taps need PIPE_LAT edges; keep the longer wait.
          if (change) begin
            ld     = 1'b1;
            ld_val = (cnt > SW_LEN) ? cnt - ONE : SW_LEN;
          end else if (done) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (change) begin
            state_d = ST_SWITCH;
            ld      = 1'b1;
            ld_val  = SW_LEN;
          end
        end
        ST_SWITCH: begin
          if (done) state_d = ST_RUN;
        end
        default: state_d = ST_DISABLED;
      endcase
    end
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_FILL) ||
              (state_d == ST_SWITCH);
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_DISABLED;
      sel_q   <= '0;
      swcnt_q <= '0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      swcnt_q <= swcnt_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign o_sw_ack   = ack_q;
  assign o_sel_taps = sel_q;
  assign o_fir_en   = en_q;
  assign o_valid    = valid_q;
  assign o_busy     = busy_q;
  assign o_sw_count = swcnt_q;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Bench for fir_tap_scheduler: timing model of the FIR window
// plus directed and randomized enable/bank-switch traffic.
module tb_fir_tap_scheduler;

  localparam int FILL = 21;
  localparam int PL   = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       req   = 1'b0;
  logic [1:0] bank  = 2'd0;
  logic       ack, fir_en, valid, busy;
  logic [1:0] sel;
  logic [7:0] swc;

  always #5 clk = ~clk;

  fir_tap_scheduler dut (
    .clk        (clk),
    .i_reset_n  (rst_n),
    .i_enable   (en),
    .i_sw_req   (req),
    .i_sw_bank  (bank),
    .o_sw_ack   (ack),
    .o_sel_taps (sel),
    .o_fir_en   (fir_en),
    .o_valid    (valid),
    .o_busy     (busy),
    .o_sw_count (swc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: time-based. The FIR output is trustworthy once the
  // filter has run FILL edges and the taps are PIPE_LAT edges old.
  int     edge_n  = 0;
  bit     m_en    = 0;
  bit     m_sw    = 0;
  bit     m_valid = 0;
  bit     m_ack   = 0;
  bit     m_busy  = 0;
  int     m_sel   = 0;
  int     m_cnt   = 0;
  longint m_vat   = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_en = 0; m_sw = 0; m_valid = 0; m_ack = 0;
      m_busy = 0; m_sel = 0; m_cnt = 0; m_vat = 0;
    end else begin
      bit in_sw, acc, diff;
      edge_n++;
      in_sw = m_en && m_sw && !m_valid;
      acc   = req && !in_sw;
      diff  = acc && (int'(bank) != m_sel);
      if (acc) m_sel = int'(bank);
      if (diff) m_cnt = (m_cnt + 1) % 256;
      if (!en) begin
        m_en = 0;
        m_sw = 0;
      end else if (!m_en) begin
        m_en  = 1;
        m_sw  = 0;
        m_vat = edge_n + FILL;
      end else if (diff) begin
        if (m_valid) begin
          m_sw  = 1;
          m_vat = edge_n + PL;
        end else if (edge_n + PL > m_vat) begin
          m_vat = edge_n + PL;
        end
      end
      m_ack   = acc;
      m_valid = m_en && (edge_n >= m_vat);
      m_busy  = m_en && !m_valid;
    end
  end

  // Per-cycle comparison plus a direct tap-age property.
  int sel_age = 0, en_age = 0, p_sel = 0;
  bit p_en = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sel_age = 0; en_age = 0; p_sel = 0; p_en = 0;
    end else begin
      chk("fir_en", int'(fir_en), int'(m_en));
      chk("valid", int'(valid), int'(m_valid));
      chk("busy", int'(busy), int'(m_busy));
      chk("ack", int'(ack), int'(m_ack));
      chk("sel", int'(sel), m_sel);
      chk("sw_count", int'(swc), m_cnt);
      sel_age = (int'(sel) != p_sel) ? 0 : sel_age + 1;
      en_age  = (fir_en && p_en) ? en_age + 1 : 0;
      p_sel   = int'(sel);
      p_en    = fir_en;
      if (valid) begin
        chk("bank_settled", int'(sel_age >= PL), 1);
        chk("window_full", int'(en_age >= FILL), 1);
      end
    end
  end

  task automatic sw_req(input int b, output int w);
    req  = 1'b1;
    bank = 2'(b);
    w    = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (!ack && w < 40);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_valid(output int d);
    d = 0;
    while (!valid && d < 60) begin
      @(posedge clk); #1;
      d++;
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_en"}, int'(fir_en), 0);
    chk({nm, "_valid"}, int'(valid), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_ack"}, int'(ack), 0);
    chk({nm, "_sel"}, int'(sel), 0);
    chk({nm, "_cnt"}, int'(swc), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int w, d, e0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_en", int'(fir_en), 0);

    // Fill timing
    en = 1'b1;
    @(posedge clk); #1;
    chk("fill_en_rise", int'(fir_en), 1);
    chk("fill_busy", int'(busy), 1);
    wait_valid(d);
    chk("fill_len", d, FILL);
    chk("run_busy", int'(busy), 0);
    @(negedge clk);

    // Bank change in RUN
    sw_req(2, w);
    chk("sw2_wait", w, 1);
    chk("sw2_sel", int'(sel), 2);
    chk("sw2_blank", int'(valid), 0);
    wait_valid(d);
    chk("sw2_blank_len", d, PL);
    chk("sw2_count", int'(swc), 1);
    @(negedge clk);

    // Same bank: ack only
    sw_req(2, w);
    chk("same_wait", w, 1);
    chk("same_valid", int'(valid), 1);
    chk("same_count", int'(swc), 1);

    // Request held through SWITCH
    sw_req(1, w);
    chk("sw1_wait", w, 1);
    sw_req(3, w);
    chk("held_wait", w, PL + 1);
    chk("held_sel", int'(sel), 3);
    wait_valid(d);
    chk("held_blank_len", d, PL);
    chk("held_count", int'(swc), 3);
    @(negedge clk);

    // Switch early in FILL keeps the schedule
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    e0 = edge_n;
    repeat (11) @(posedge clk);
    @(negedge clk);
    sw_req(1, w);
    chk("fill10_wait", w, 1);
    wait_valid(d);
    chk("fill10_len", edge_n - e0, FILL);
    chk("fill10_count", int'(swc), 4);
    @(negedge clk);

    // Switch late in FILL extends it
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    e0 = edge_n;
    repeat (18) @(posedge clk);
    @(negedge clk);
    sw_req(0, w);
    chk("fill3_wait", w, 1);
    wait_valid(d);
    chk("fill3_len", edge_n - e0, 24);
    @(negedge clk);

    // Disable during SWITCH
    sw_req(2, w);
    en = 1'b0;
    @(posedge clk); #1;
    chk("dis_valid", int'(valid), 0);
    chk("dis_en", int'(fir_en), 0);
    chk("dis_busy", int'(busy), 0);
    chk("dis_sel", int'(sel), 2);
    @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);

    // Async reset mid-FILL
    #2 rst_n = 1'b0;
    #1 chk_all_zero("areset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_en", int'(fir_en), 1);
    chk("restart_busy", int'(busy), 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i == 2000) begin
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rnd_reset");
      end
      if (i == 2002) rst_n = 1'b1;
      if (req && ack) begin
        req = 1'b0;
      end else if (!req && $urandom_range(0, 9) == 0) begin
        req  = 1'b1;
        bank = 2'($urandom_range(0, 3));
      end
      en = ($urandom_range(0, 199) < 3) ? 1'b0 : 1'b1;
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
